// File: rtl/difftest_commit_packer.sv
// difftest_commit_packer
//   Producer side of the difftest commit interface. Registers the per-cycle
//   retire events from the commit stage once, compacts the two commit lanes,
//   assigns running commit indices, encodes LA32R store/load valid masks and
//   byte-aligns store data for DiffBridge.
// Ports
//   clock, reset_n      : core clock, asynchronous active-low reset
//   cmt_*               : two-lane retire information, lane i in bits [i*W +: W]
//   ex_*                : exception / eret event (faulting instr is never a commit)
//   st_* / ld_*         : one store and one load event, tied to a commit lane
//   d_*_0 / d_*_1       : compacted, registered lane outputs
//   d_excp_* .. d_load* : registered exception, store and load outputs
module difftest_commit_packer #(
    parameter int IDX_W   = 8,
    parameter int TIMER_W = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         cmt_valid,
    input  logic [63:0]        cmt_pc,
    input  logic [63:0]        cmt_instr,
    input  logic [1:0]         cmt_wen,
    input  logic [9:0]         cmt_wdest,
    input  logic [63:0]        cmt_wdata,
    input  logic [1:0]         cmt_mmio,
    input  logic [1:0]         cmt_is_cnt,
    input  logic [1:0]         cmt_tlbfill,
    input  logic [9:0]         cmt_tlbfill_idx,
    input  logic [1:0]         cmt_csr_rstat,
    input  logic [63:0]        cmt_csr_data,
    input  logic               ex_valid,
    input  logic               ex_eret,
    input  logic [10:0]        ex_intr_no,
    input  logic [5:0]         ex_ecode,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_inst,
    input  logic               st_valid,
    input  logic               st_lane,
    input  logic [1:0]         st_type,
    input  logic [31:0]        st_paddr,
    input  logic [31:0]        st_vaddr,
    input  logic [31:0]        st_data,
    input  logic               ld_valid,
    input  logic               ld_lane,
    input  logic [2:0]         ld_type,
    input  logic [31:0]        ld_paddr,
    input  logic [31:0]        ld_vaddr,
    output logic               d_instrvalid_0,
    output logic [63:0]        d_the_pc_0,
    output logic [31:0]        d_instr_0,
    output logic               d_skip_0,
    output logic               d_is_tlbfill_0,
    output logic [4:0]         d_tlbfill_index_0,
    output logic               d_is_cntinst_0,
    output logic [63:0]        d_timer_64_value_0,
    output logic               d_wen_0,
    output logic [7:0]         d_wdest_0,
    output logic [63:0]        d_wdata_0,
    output logic               d_csr_rstat_0,
    output logic [31:0]        d_csr_data_0,
    output logic [IDX_W-1:0]   d_index_0,
    output logic               d_instrvalid_1,
    output logic [63:0]        d_the_pc_1,
    output logic [31:0]        d_instr_1,
    output logic               d_skip_1,
    output logic               d_is_tlbfill_1,
    output logic [4:0]         d_tlbfill_index_1,
    output logic               d_is_cntinst_1,
    output logic [63:0]        d_timer_64_value_1,
    output logic               d_wen_1,
    output logic [7:0]         d_wdest_1,
    output logic [63:0]        d_wdata_1,
    output logic               d_csr_rstat_1,
    output logic [31:0]        d_csr_data_1,
    output logic [IDX_W-1:0]   d_index_1,
    output logic               d_excp_valid,
    output logic               d_eret,
    output logic [10:0]        d_intr_no,
    output logic [5:0]         d_cause,
    output logic [31:0]        d_exception_pc,
    output logic [31:0]        d_exception_inst,
    output logic [IDX_W-1:0]   d_store_index,
    output logic [7:0]         d_store_valid,
    output logic [63:0]        d_store_paddr,
    output logic [63:0]        d_store_vaddr,
    output logic [63:0]        d_store_data,
    output logic [IDX_W-1:0]   d_load_index,
    output logic [7:0]         d_load_valid,
    output logic [63:0]        d_load_paddr,
    output logic [63:0]        d_load_vaddr
);

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc;
        logic [31:0]        instr;
        logic               skip;
        logic               tlbfill;
        logic [4:0]         tlbfill_idx;
        logic               is_cnt;
        logic [TIMER_W-1:0] timer;
        logic               wen;
        logic [4:0]         wdest;
        logic [31:0]        wdata;
        logic               csr_rstat;
        logic [31:0]        csr_data;
        logic [IDX_W-1:0]   index;
    } lane_t;

    typedef struct packed {
        logic        valid;
        logic        eret;
        logic [10:0] intr_no;
        logic [5:0]  cause;
        logic [31:0] pc;
        logic [31:0] inst;
    } excp_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [7:0]       mask;
        logic [31:0]      paddr;
        logic [31:0]      vaddr;
        logic [31:0]      data;
    } store_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [7:0]       mask;
        logic [31:0]      paddr;
        logic [31:0]      vaddr;
    } load_t;

    function automatic logic [7:0] store_mask(input logic [1:0] t);
        case (t)
            2'd0:    store_mask = 8'h01;
            2'd1:    store_mask = 8'h02;
            2'd2:    store_mask = 8'h04;
            2'd3:    store_mask = 8'h08;
            default: store_mask = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] load_mask(input logic [2:0] t);
        case (t)
            3'd0:    load_mask = 8'h01;
            3'd1:    load_mask = 8'h02;
            3'd2:    load_mask = 8'h04;
            3'd3:    load_mask = 8'h08;
            3'd4:    load_mask = 8'h10;
            3'd5:    load_mask = 8'h20;
            default: load_mask = 8'h00;
        endcase
    endfunction

    // Place the stored bytes on their byte lanes within the aligned word.
    function automatic logic [31:0] align_store(input logic [1:0] t, input logic [1:0] off,
                                                input logic [31:0] data);
        case (t)
            2'd0:    align_store = {24'h000000, data[7:0]} << {off, 3'b000};
            2'd1:    align_store = {16'h0000, data[15:0]} << {off[1], 4'b0000};
            default: align_store = data;
        endcase
    endfunction

    lane_t              raw_s [2];
    lane_t              lane0_d, lane0_q, lane1_d, lane1_q;
    excp_t              excp_d, excp_q;
    store_t             store_d, store_q;
    load_t              load_d, load_q;
    logic [IDX_W-1:0]   idx_d, idx_q;
    logic [TIMER_W-1:0] timer_d, timer_q;
    logic [IDX_W-1:0]   st_idx_s, ld_idx_s;
    logic [7:0]         ld_mask_s;

    // Per-source-lane field extraction, then compaction onto the output lanes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            raw_s[i]             = '0;
            raw_s[i].valid       = 1'b1;
            raw_s[i].pc          = cmt_pc[32*i +: 32];
            raw_s[i].instr       = cmt_instr[32*i +: 32];
            raw_s[i].skip        = cmt_mmio[i] | cmt_is_cnt[i];
            raw_s[i].tlbfill     = cmt_tlbfill[i];
            raw_s[i].tlbfill_idx = cmt_tlbfill_idx[5*i +: 5];
            raw_s[i].is_cnt      = cmt_is_cnt[i];
            raw_s[i].timer       = timer_q;
            // Writes to r0 are architecturally invisible, so never report them.
            raw_s[i].wen         = cmt_wen[i] & (cmt_wdest[5*i +: 5] != 5'd0);
            raw_s[i].wdest       = cmt_wdest[5*i +: 5];
            raw_s[i].wdata       = cmt_wdata[32*i +: 32];
            raw_s[i].csr_rstat   = cmt_csr_rstat[i];
            raw_s[i].csr_data    = cmt_csr_data[32*i +: 32];
        end
        lane0_d = '0;
        lane1_d = '0;
        case (cmt_valid)
            2'b01: begin
                lane0_d       = raw_s[0];
                lane0_d.index = idx_q;
            end
            2'b10: begin
                lane0_d       = raw_s[1];
                lane0_d.index = idx_q;
            end
            2'b11: begin
                lane0_d       = raw_s[0];
                lane0_d.index = idx_q;
                lane1_d       = raw_s[1];
                lane1_d.index = idx_q + IDX_ONE;
            end
            default: begin
                lane0_d = '0;
                lane1_d = '0;
            end
        endcase
        idx_d   = idx_q + IDX_W'(cmt_valid[0]) + IDX_W'(cmt_valid[1]);
        timer_d = timer_q + {{(TIMER_W-1){1'b0}}, 1'b1};
    end

    // Exception, store and load events; memory events attach to their compacted lane index.
    always_comb begin
        excp_d = '0;
        if (ex_valid) begin
            excp_d = '{valid: 1'b1, eret: ex_eret, intr_no: ex_intr_no, cause: ex_ecode,
                       pc: ex_pc, inst: ex_inst};
        end else begin
            excp_d = '0;
        end

        // Lane 1 lands on output lane 1 only when lane 0 also committed.
        st_idx_s = (st_lane & cmt_valid[0]) ? idx_q + IDX_ONE : idx_q;
        ld_idx_s = (ld_lane & cmt_valid[0]) ? idx_q + IDX_ONE : idx_q;
        ld_mask_s = load_mask(ld_type);

        store_d = '0;
        if (st_valid && cmt_valid[st_lane]) begin
            store_d = '{index: st_idx_s, mask: store_mask(st_type), paddr: st_paddr,
                        vaddr: st_vaddr, data: align_store(st_type, st_paddr[1:0], st_data)};
        end else begin
            store_d = '0;
        end

        load_d = '0;
        if (ld_valid && cmt_valid[ld_lane] && (ld_mask_s != 8'h00)) begin
            load_d = '{index: ld_idx_s, mask: ld_mask_s, paddr: ld_paddr, vaddr: ld_vaddr};
        end else begin
            load_d = '0;
        end
    end

    // Output registers, commit index counter and free-running timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane0_q <= '0;
            lane1_q <= '0;
            excp_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            excp_q  <= excp_d;
            store_q <= store_d;
            load_q  <= load_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    assign d_instrvalid_0     = lane0_q.valid;
    assign d_the_pc_0         = {32'h00000000, lane0_q.pc};
    assign d_instr_0          = lane0_q.instr;
    assign d_skip_0           = lane0_q.skip;
    assign d_is_tlbfill_0     = lane0_q.tlbfill;
    assign d_tlbfill_index_0  = lane0_q.tlbfill_idx;
    assign d_is_cntinst_0     = lane0_q.is_cnt;
    assign d_timer_64_value_0 = 64'(lane0_q.timer);
    assign d_wen_0            = lane0_q.wen;
    assign d_wdest_0          = {3'b000, lane0_q.wdest};
    assign d_wdata_0          = {32'h00000000, lane0_q.wdata};
    assign d_csr_rstat_0      = lane0_q.csr_rstat;
    assign d_csr_data_0       = lane0_q.csr_data;
    assign d_index_0          = lane0_q.index;

    assign d_instrvalid_1     = lane1_q.valid;
    assign d_the_pc_1         = {32'h00000000, lane1_q.pc};
    assign d_instr_1          = lane1_q.instr;
    assign d_skip_1           = lane1_q.skip;
    assign d_is_tlbfill_1     = lane1_q.tlbfill;
    assign d_tlbfill_index_1  = lane1_q.tlbfill_idx;
    assign d_is_cntinst_1     = lane1_q.is_cnt;
    assign d_timer_64_value_1 = 64'(lane1_q.timer);
    assign d_wen_1            = lane1_q.wen;
    assign d_wdest_1          = {3'b000, lane1_q.wdest};
    assign d_wdata_1          = {32'h00000000, lane1_q.wdata};
    assign d_csr_rstat_1      = lane1_q.csr_rstat;
    assign d_csr_data_1       = lane1_q.csr_data;
    assign d_index_1          = lane1_q.index;

    assign d_excp_valid       = excp_q.valid;
    assign d_eret             = excp_q.eret;
    assign d_intr_no          = excp_q.intr_no;
    assign d_cause            = excp_q.cause;
    assign d_exception_pc     = excp_q.pc;
    assign d_exception_inst   = excp_q.inst;

    assign d_store_index      = store_q.index;
    assign d_store_valid      = store_q.mask;
    assign d_store_paddr      = {32'h00000000, store_q.paddr};
    assign d_store_vaddr      = {32'h00000000, store_q.vaddr};
    assign d_store_data       = {32'h00000000, store_q.data};

    assign d_load_index       = load_q.index;
    assign d_load_valid       = load_q.mask;
    assign d_load_paddr       = {32'h00000000, load_q.paddr};
    assign d_load_vaddr       = {32'h00000000, load_q.vaddr};

endmodule

// File: tb/tb_difftest_commit_packer.sv
// Scoreboard bench for difftest_commit_packer: inputs are driven on the falling
// edge, the reference model pushes the expected registered outputs, and a
// monitor pops and compares one entry just after each rising edge.
module tb_difftest_commit_packer;

    typedef struct packed {
        logic        v;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        tlb;
        logic [4:0]  tlbidx;
        logic        cnt;
        logic [63:0] timer;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        rstat;
        logic [31:0] csr;
        logic [7:0]  idx;
    } lane_t;

    typedef struct packed {
        lane_t         l0;
        lane_t         l1;
        logic [82:0]   ex;
        logic [207:0]  st;
        logic [143:0]  ld;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  cmt_valid, cmt_wen, cmt_mmio, cmt_is_cnt, cmt_tlbfill, cmt_csr_rstat;
    logic [63:0] cmt_pc, cmt_instr, cmt_wdata, cmt_csr_data;
    logic [9:0]  cmt_wdest, cmt_tlbfill_idx;
    logic        ex_valid, ex_eret;
    logic [10:0] ex_intr_no;
    logic [5:0]  ex_ecode;
    logic [31:0] ex_pc, ex_inst;
    logic        st_valid, st_lane;
    logic [1:0]  st_type;
    logic [31:0] st_paddr, st_vaddr, st_data;
    logic        ld_valid, ld_lane;
    logic [2:0]  ld_type;
    logic [31:0] ld_paddr, ld_vaddr;

    logic        d_instrvalid_0, d_skip_0, d_is_tlbfill_0, d_is_cntinst_0, d_wen_0, d_csr_rstat_0;
    logic        d_instrvalid_1, d_skip_1, d_is_tlbfill_1, d_is_cntinst_1, d_wen_1, d_csr_rstat_1;
    logic [63:0] d_the_pc_0, d_timer_64_value_0, d_wdata_0, d_the_pc_1, d_timer_64_value_1, d_wdata_1;
    logic [31:0] d_instr_0, d_csr_data_0, d_instr_1, d_csr_data_1;
    logic [4:0]  d_tlbfill_index_0, d_tlbfill_index_1;
    logic [7:0]  d_wdest_0, d_index_0, d_wdest_1, d_index_1;
    logic        d_excp_valid, d_eret;
    logic [10:0] d_intr_no;
    logic [5:0]  d_cause;
    logic [31:0] d_exception_pc, d_exception_inst;
    logic [7:0]  d_store_index, d_store_valid, d_load_index, d_load_valid;
    logic [63:0] d_store_paddr, d_store_vaddr, d_store_data, d_load_paddr, d_load_vaddr;

    difftest_commit_packer #(.IDX_W(8), .TIMER_W(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .cmt_wen(cmt_wen),
        .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .cmt_mmio(cmt_mmio), .cmt_is_cnt(cmt_is_cnt),
        .cmt_tlbfill(cmt_tlbfill), .cmt_tlbfill_idx(cmt_tlbfill_idx), .cmt_csr_rstat(cmt_csr_rstat),
        .cmt_csr_data(cmt_csr_data),
        .ex_valid(ex_valid), .ex_eret(ex_eret), .ex_intr_no(ex_intr_no), .ex_ecode(ex_ecode),
        .ex_pc(ex_pc), .ex_inst(ex_inst),
        .st_valid(st_valid), .st_lane(st_lane), .st_type(st_type), .st_paddr(st_paddr),
        .st_vaddr(st_vaddr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_lane(ld_lane), .ld_type(ld_type), .ld_paddr(ld_paddr),
        .ld_vaddr(ld_vaddr),
        .d_instrvalid_0(d_instrvalid_0), .d_the_pc_0(d_the_pc_0), .d_instr_0(d_instr_0),
        .d_skip_0(d_skip_0), .d_is_tlbfill_0(d_is_tlbfill_0), .d_tlbfill_index_0(d_tlbfill_index_0),
        .d_is_cntinst_0(d_is_cntinst_0), .d_timer_64_value_0(d_timer_64_value_0), .d_wen_0(d_wen_0),
        .d_wdest_0(d_wdest_0), .d_wdata_0(d_wdata_0), .d_csr_rstat_0(d_csr_rstat_0),
        .d_csr_data_0(d_csr_data_0), .d_index_0(d_index_0),
        .d_instrvalid_1(d_instrvalid_1), .d_the_pc_1(d_the_pc_1), .d_instr_1(d_instr_1),
        .d_skip_1(d_skip_1), .d_is_tlbfill_1(d_is_tlbfill_1), .d_tlbfill_index_1(d_tlbfill_index_1),
        .d_is_cntinst_1(d_is_cntinst_1), .d_timer_64_value_1(d_timer_64_value_1), .d_wen_1(d_wen_1),
        .d_wdest_1(d_wdest_1), .d_wdata_1(d_wdata_1), .d_csr_rstat_1(d_csr_rstat_1),
        .d_csr_data_1(d_csr_data_1), .d_index_1(d_index_1),
        .d_excp_valid(d_excp_valid), .d_eret(d_eret), .d_intr_no(d_intr_no), .d_cause(d_cause),
        .d_exception_pc(d_exception_pc), .d_exception_inst(d_exception_inst),
        .d_store_index(d_store_index), .d_store_valid(d_store_valid), .d_store_paddr(d_store_paddr),
        .d_store_vaddr(d_store_vaddr), .d_store_data(d_store_data),
        .d_load_index(d_load_index), .d_load_valid(d_load_valid), .d_load_paddr(d_load_paddr),
        .d_load_vaddr(d_load_vaddr)
    );

    always #5 clock = ~clock;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_push  = 0;
    int          n_pop   = 0;
    logic [7:0]  idx_m   = 8'd0;
    logic [63:0] tcnt    = 64'd0;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic lane_t act_lane0();
        return {d_instrvalid_0, d_the_pc_0, d_instr_0, d_skip_0, d_is_tlbfill_0, d_tlbfill_index_0,
                d_is_cntinst_0, d_timer_64_value_0, d_wen_0, d_wdest_0, d_wdata_0, d_csr_rstat_0,
                d_csr_data_0, d_index_0};
    endfunction

    function automatic lane_t act_lane1();
        return {d_instrvalid_1, d_the_pc_1, d_instr_1, d_skip_1, d_is_tlbfill_1, d_tlbfill_index_1,
                d_is_cntinst_1, d_timer_64_value_1, d_wen_1, d_wdest_1, d_wdata_1, d_csr_rstat_1,
                d_csr_data_1, d_index_1};
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_lane0"}, 320'(act_lane0()), 320'(e.l0));
        chk({tag, "_lane1"}, 320'(act_lane1()), 320'(e.l1));
        chk({tag, "_excp"}, 320'({d_excp_valid, d_eret, d_intr_no, d_cause, d_exception_pc,
                                  d_exception_inst}), 320'(e.ex));
        chk({tag, "_store"}, 320'({d_store_index, d_store_valid, d_store_paddr, d_store_vaddr,
                                   d_store_data}), 320'(e.st));
        chk({tag, "_load"}, 320'({d_load_index, d_load_valid, d_load_paddr, d_load_vaddr}),
            320'(e.ld));
    endtask

    // Reference model: list the committing lanes in program order, number them
    // from the running index, and attach memory events to their list position.
    task automatic issue();
        int    src[$];
        int    spos, lpos;
        exp_t  e;
        lane_t l;
        logic [31:0] sd;
        e = '0;
        for (int i = 0; i < 2; i++) if (cmt_valid[i]) src.push_back(i);
        for (int k = 0; k < src.size(); k++) begin
            int s = src[k];
            l        = '0;
            l.v      = 1'b1;
            l.pc     = {32'h0, cmt_pc[32*s +: 32]};
            l.instr  = cmt_instr[32*s +: 32];
            l.skip   = cmt_mmio[s] | cmt_is_cnt[s];
            l.tlb    = cmt_tlbfill[s];
            l.tlbidx = cmt_tlbfill_idx[5*s +: 5];
            l.cnt    = cmt_is_cnt[s];
            l.timer  = tcnt;
            l.wdest  = {3'b000, cmt_wdest[5*s +: 5]};
            l.wen    = cmt_wen[s] && (l.wdest != 8'd0);
            l.wdata  = {32'h0, cmt_wdata[32*s +: 32]};
            l.rstat  = cmt_csr_rstat[s];
            l.csr    = cmt_csr_data[32*s +: 32];
            l.idx    = idx_m + 8'(k);
            if (k == 0) e.l0 = l;
            else        e.l1 = l;
        end
        if (ex_valid) e.ex = {1'b1, ex_eret, ex_intr_no, ex_ecode, ex_pc, ex_inst};
        spos = -1;
        lpos = -1;
        for (int k = 0; k < src.size(); k++) begin
            if (src[k] == int'(st_lane)) spos = k;
            if (src[k] == int'(ld_lane)) lpos = k;
        end
        if (st_valid && spos >= 0) begin
            case (st_type)
                2'd0:    sd = (st_data & 32'h000000FF) << (8 * st_paddr[1:0]);
                2'd1:    sd = (st_data & 32'h0000FFFF) << (16 * st_paddr[1]);
                default: sd = st_data;
            endcase
            e.st = {idx_m + 8'(spos), 8'h01 << st_type, 32'h0, st_paddr, 32'h0, st_vaddr, 32'h0, sd};
        end
        if (ld_valid && lpos >= 0 && ld_type <= 3'd5)
            e.ld = {idx_m + 8'(lpos), 8'h01 << ld_type, 32'h0, ld_paddr, 32'h0, ld_vaddr};
        idx_m = idx_m + 8'(src.size());
        tcnt  = tcnt + 64'd1;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic set_idle();
        cmt_valid = 2'b00; cmt_pc = 64'h0; cmt_instr = 64'h0; cmt_wen = 2'b00; cmt_wdest = 10'h0;
        cmt_wdata = 64'h0; cmt_mmio = 2'b00; cmt_is_cnt = 2'b00; cmt_tlbfill = 2'b00;
        cmt_tlbfill_idx = 10'h0; cmt_csr_rstat = 2'b00; cmt_csr_data = 64'h0;
        ex_valid = 1'b0; ex_eret = 1'b0; ex_intr_no = 11'h0; ex_ecode = 6'h0;
        ex_pc = 32'h0; ex_inst = 32'h0;
        st_valid = 1'b0; st_lane = 1'b0; st_type = 2'd0; st_paddr = 32'h0; st_vaddr = 32'h0;
        st_data = 32'h0;
        ld_valid = 1'b0; ld_lane = 1'b0; ld_type = 3'd0; ld_paddr = 32'h0; ld_vaddr = 32'h0;
    endtask

    task automatic set_random();
        cmt_valid = 2'($urandom); cmt_pc = {$urandom, $urandom}; cmt_instr = {$urandom, $urandom};
        cmt_wen = 2'($urandom); cmt_wdest = 10'($urandom); cmt_wdata = {$urandom, $urandom};
        cmt_mmio = 2'($urandom); cmt_is_cnt = 2'($urandom); cmt_tlbfill = 2'($urandom);
        cmt_tlbfill_idx = 10'($urandom); cmt_csr_rstat = 2'($urandom);
        cmt_csr_data = {$urandom, $urandom};
        ex_valid = 1'($urandom); ex_eret = 1'($urandom); ex_intr_no = 11'($urandom);
        ex_ecode = 6'($urandom); ex_pc = $urandom; ex_inst = $urandom;
        st_valid = 1'($urandom); st_lane = 1'($urandom); st_type = 2'($urandom_range(0, 3));
        st_paddr = $urandom; st_vaddr = $urandom; st_data = $urandom;
        ld_valid = 1'($urandom); ld_lane = 1'($urandom); ld_type = 3'($urandom_range(0, 7));
        ld_paddr = $urandom; ld_vaddr = $urandom;
    endtask

    // Assert reset on a falling edge, check the outputs clear at once, release.
    task automatic do_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_outputs(tag, '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        idx_m   = 8'd0;
        tcnt    = 64'd0;
        set_idle();
        issue();
    endtask

    // Monitor: compare one expected entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                check_outputs("sb", e);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clock);
        #1;
        check_outputs("por", '0);
        @(negedge clock);
        reset_n = 1'b1;
        issue();

        // Dual commit from reset, then a single lane-0 commit.
        @(negedge clock); set_idle();
        cmt_valid = 2'b11; cmt_pc = {32'h1c000004, 32'h1c000000}; issue();
        @(negedge clock); set_idle();
        cmt_valid = 2'b01; cmt_pc = {32'h0, 32'h1c000008}; issue();
        // Lane 1 only: compacts onto output lane 0.
        @(negedge clock); set_idle();
        cmt_valid = 2'b10; cmt_pc = {32'h1c000010, 32'h0}; cmt_wen = 2'b10;
        cmt_wdest = {5'd4, 5'd0}; cmt_wdata = {32'hCAFEF00D, 32'h0}; issue();
        // st.b at byte 3, then st.h on the upper half-word.
        @(negedge clock); set_idle();
        cmt_valid = 2'b01; st_valid = 1'b1; st_type = 2'd0; st_paddr = 32'h00001003;
        st_vaddr = 32'h80001003; st_data = 32'h000000AB; issue();
        @(negedge clock); set_idle();
        cmt_valid = 2'b01; st_valid = 1'b1; st_type = 2'd1; st_paddr = 32'h00002002;
        st_vaddr = 32'h80002002; st_data = 32'h00001234;
        ld_valid = 1'b1; ld_lane = 1'b0; ld_type = 3'd5; ld_paddr = 32'h3000; issue();
        // Exception alongside an older commit writing r0.
        @(negedge clock); set_idle();
        cmt_valid = 2'b01; cmt_wen = 2'b01; cmt_wdest = 10'h0; ex_valid = 1'b1;
        ex_ecode = 6'h0B; ex_pc = 32'h1c000020; ex_inst = 32'h002b0000; issue();
        @(negedge clock); set_idle(); issue();
        // Store on a lane that is not committing is dropped.
        @(negedge clock); set_idle();
        cmt_valid = 2'b01; st_valid = 1'b1; st_lane = 1'b1; st_type = 2'd2; issue();

        // Index wrap through 255 -> 0 with dual commits.
        for (int i = 0; i < 130; i++) begin
            @(negedge clock); set_idle();
            cmt_valid = 2'b11; cmt_pc = {$urandom, $urandom}; issue();
        end

        // Randomised traffic with a reset in the middle of a dual-commit burst.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(negedge clock); set_random(); cmt_valid = 2'b11; issue();
                do_reset("midrst");
                @(negedge clock); set_idle(); cmt_valid = 2'b11; issue();
            end
            @(negedge clock);
            set_random();
            issue();
        end

        @(negedge clock); set_idle(); issue();
        repeat (3) @(negedge clock);
        chk("sb_drained", 320'(exp_q.size()), 320'(0));
        chk("sb_pop_count", 320'(n_pop), 320'(n_push));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
